// File: rtl/uart_tx.sv
// UART transmitter: one byte per ready/valid handshake, sent LSB-first with
// start bit, optional odd/even parity and one or two stop bits. Line idles high.
module uart_tx (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  io_config_dataType,
  input  logic        io_config_stopType,
  input  logic [1:0]  io_config_parityType,
  input  logic [19:0] io_config_clockDivider,
  input  logic        io_data_valid,
  output logic        io_data_ready,
  input  logic [7:0]  io_data_bits,
  output logic        io_tx,
  output logic        io_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic        tx_q, tx_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        stop_idx_q, stop_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        stop_type_q, stop_type_d;
  logic [1:0]  par_type_q, par_type_d;
  logic [19:0] div_q, div_d;

  logic xfer, bit_end, par_en;
  logic unused_data_type;

  // Data width is fixed at 8 bits; the data-type field is accepted but not decoded.
  assign unused_data_type = ^io_config_dataType;

  assign io_data_ready = (state_q == IDLE);
  assign io_busy       = (state_q != IDLE);
  assign io_tx         = tx_q;

  assign xfer    = io_data_valid && (state_q == IDLE);
  assign bit_end = (cnt_q == 20'd0);
  assign par_en  = (par_type_q == 2'd1) || (par_type_q == 2'd2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    shift_d     = shift_q;
    stop_type_d = stop_type_q;
    par_type_d  = par_type_q;
    div_d       = div_q;

    if (state_q == IDLE) begin
      if (xfer) begin
        state_d     = START;
        shift_d     = io_data_bits;
        stop_type_d = io_config_stopType;
        par_type_d  = io_config_parityType;
        div_d       = io_config_clockDivider;
        cnt_d       = io_config_clockDivider;
        bit_idx_d   = 3'd0;
        stop_idx_d  = 1'b0;
      end
    end else if (!bit_end) begin
      cnt_d = cnt_q - 20'd1;
    end else begin
      // Reload rather than decrement from zero: each bit lasts div+1 cycles.
      cnt_d = div_q;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) begin
            state_d    = par_en ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        PARITY: begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
        STOP: begin
          if (stop_idx_q == stop_type_q) state_d = IDLE;
          else                           stop_idx_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Line level is derived from the next state so io_tx stays a plain flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      PARITY:  tx_d = (par_type_q == 2'd2) ? ^shift_q : ~^shift_q;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tx_q        <= 1'b1;
      cnt_q       <= 20'd0;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      shift_q     <= 8'd0;
      stop_type_q <= 1'b0;
      par_type_q  <= 2'd0;
      div_q       <= 20'd0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      shift_q     <= shift_d;
      stop_type_q <= stop_type_d;
      par_type_q  <= par_type_d;
      div_q       <= div_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues expected frames at each
// handshake, a monitor checks the serial line cycle by cycle against them.
module tb_uart_tx;

  logic        clk;
  logic        reset;
  logic [1:0]  io_config_dataType;
  logic        io_config_stopType;
  logic [1:0]  io_config_parityType;
  logic [19:0] io_config_clockDivider;
  logic        io_data_valid;
  logic        io_data_ready;
  logic [7:0]  io_data_bits;
  logic        io_tx;
  logic        io_busy;

  uart_tx dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_config_dataType     (io_config_dataType),
    .io_config_stopType     (io_config_stopType),
    .io_config_parityType   (io_config_parityType),
    .io_config_clockDivider (io_config_clockDivider),
    .io_data_valid          (io_data_valid),
    .io_data_ready          (io_data_ready),
    .io_data_bits           (io_data_bits),
    .io_tx                  (io_tx),
    .io_busy                (io_busy)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    int         par;       // 0 none, 1 odd, 2 even
    int         nstop;
    longint     start;     // cycle index at which the start bit must appear
  } frame_t;

  frame_t exp_q[$];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_cfg(input int div, input int par, input int stop);
    io_config_clockDivider = div[19:0];
    io_config_parityType   = par[1:0];
    io_config_stopType     = stop[0];
    io_config_dataType     = 2'($urandom_range(0, 3));
  endtask

  // Called on the negedge preceding the transfer edge, with the offered byte on the bus.
  task automatic exp_push(input logic [7:0] d);
    frame_t f;
    f.data  = d;
    f.div   = int'(io_config_clockDivider);
    f.par   = (io_config_parityType == 2'd1 || io_config_parityType == 2'd2) ?
              int'(io_config_parityType) : 0;
    f.nstop = io_config_stopType ? 2 : 1;
    f.start = cyc + 1;
    exp_q.push_back(f);
  endtask

  task automatic send(input logic [7:0] d, input bit hold);
    int t = 0;
    io_data_valid = 1'b1;
    forever begin
      if (io_data_ready) begin
        io_data_bits = d;
        exp_push(d);
        @(negedge clk);
        break;
      end
      // Bus contents are irrelevant while the transmitter is not ready.
      io_data_bits = 8'($urandom);
      @(negedge clk);
      t++;
      if (t > 2000) begin
        chk("send_timeout", 32'(t), 32'd0);
        break;
      end
    end
    if (!hold) io_data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((io_busy || exp_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: a falling line outside a frame is a start bit; check every cycle of the frame.
  initial begin
    frame_t e;
    logic   bits[$];
    int     ones;
    bit     aborted;
    forever begin
      @(posedge clk);
      #1;
      if (reset || io_tx) continue;
      if (exp_q.size() == 0) begin
        chk("spurious_start", 32'(io_tx), 32'd1);
        continue;
      end
      e = exp_q.pop_front();
      chk("start_cycle", 32'(cyc), 32'(e.start));
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(e.data[i]);
      ones = $countones(e.data);
      if (e.par == 1) bits.push_back(((ones + 1) % 2) == 1);
      if (e.par == 2) bits.push_back((ones % 2) == 1);
      for (int i = 0; i < e.nstop; i++) bits.push_back(1'b1);
      aborted = 1'b0;
      for (int b = 0; b < bits.size() && !aborted; b++) begin
        for (int k = 0; k <= e.div; k++) begin
          if (b != 0 || k != 0) begin
            @(posedge clk);
            #1;
            if (reset) begin
              aborted = 1'b1;
              break;
            end
          end
          chk($sformatf("frame_%02h_bit%0d", e.data, b),
              {29'd0, io_tx, io_data_ready, io_busy}, {29'd0, bits[b], 1'b0, 1'b1});
        end
      end
      if (!aborted) begin
        @(posedge clk);
        #1;
        if (!reset)
          chk("idle_gap", {29'd0, io_tx, io_data_ready, io_busy}, {29'd0, 1'b1, 1'b1, 1'b0});
      end
    end
  end

  initial begin
    bit hold;
    reset         = 1'b1;
    io_data_valid = 1'b0;
    io_data_bits  = 8'd0;
    set_cfg(3, 0, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rst_state", {29'd0, io_tx, io_data_ready, io_busy}, {29'd0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    set_cfg(3, 0, 0); send(8'hA5, 0); wait_idle();
    set_cfg(3, 1, 0); send(8'hA5, 0); wait_idle();
    set_cfg(3, 2, 0); send(8'hA5, 0); wait_idle();
    set_cfg(0, 0, 1); send(8'h00, 0); wait_idle();
    set_cfg(0, 3, 0); send(8'hFF, 0); wait_idle();

    // Back-to-back with valid held high.
    set_cfg(3, 0, 0); send(8'h55, 1); send(8'hAA, 0); wait_idle();

    // Config changed while a frame is in flight.
    set_cfg(2, 2, 1); send(8'h3C, 0);
    repeat (5) @(negedge clk);
    set_cfg(5, 1, 0);
    wait_idle();
    send(8'hC3, 0); wait_idle();

    // Reset in the middle of data bit 3.
    set_cfg(3, 0, 0); send(8'h96, 0);
    repeat (17) @(negedge clk);
    chk("busy_before_reset", 32'(io_busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset", {29'd0, io_tx, io_data_ready, io_busy}, {29'd0, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    reset = 1'b0;
    send(8'h5A, 0); wait_idle();

    // Randomized traffic, configs shifting between (and during) frames.
    for (int n = 0; n < 40; n++) begin
      set_cfg($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      hold = 1'($urandom_range(0, 1));
      send(8'($urandom), hold);
    end
    io_data_valid = 1'b0;
    wait_idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
